ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage opcode into EX, MEM and WB control bundles.
- Carries the bundles through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use stall detection, branch/jump flush, and illegal-opcode capture.
- Sits between the instruction register and the datapath stage muxes; it is the only source of control for all later stages.

Parameters:
- OPCODE_W, 4: opcode width. Codes above the defined table decode as illegal.
- ALUOP_W, 3: ALU operation field width.
- REG_W, 6: register specifier width, used for hazard compare.
- CNT_W, 8: illegal-opcode counter width. The counter saturates.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  OPCODE_W  opcode in ID.
- id_rs  in  REG_W  source 1 specifier.
- id_rt  in  REG_W  source 2 specifier.
- id_rd  in  REG_W  destination specifier.
- flush  in  1  branch/jump resolved taken; the instruction is in the MEM stage this cycle.
- stall_out  out  1  holds PC and IF/ID for this cycle.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_alu_op  out  ALUOP_W  ALU operation.
- ex_rd  out  REG_W  ID/EX destination.
- mem_valid  out  1  EX/MEM holds a real instruction.
- mem_ctrl  out  7  {MemRead, MemWrite, RegWrite, MemToReg, PCtoReg, Branch, Jump}.
- wb_valid  out  1  MEM/WB holds a real instruction.
- wb_ctrl  out  3  {RegWrite, MemToReg, PCtoReg}.
- wb_rd  out  REG_W  writeback destination.
- illegal_op  out  1  sticky: an illegal opcode has been issued.
- illegal_cnt  out  CNT_W  number of illegal opcodes issued.

Behaviour:
- Reset (async, rst_n=0): every register and every output is 0. Asserting reset mid-stream discards all in-flight bundles immediately.
- Decode table. Format is opcode: ALUOp, MemRead, MemWrite | RegWrite, MemToReg, PCtoReg, Branch, Jump.
  - 0000 NOP: 011, 0, 0 | 00000
  - 1111 SVPC: 111, 0, 0 | 10100
  - 1110 LD: 111, 1, 0 | 11000
  - 0011 ST: 111, 0, 1 | 00000
  - 0100 ADD: 100, 0, 0 | 10000
  - 0101 INC: 010, 0, 0 | 10000
  - 0110 NEG: 001, 0, 0 | 10000
  - 0111 SUB: 000, 0, 0 | 10000
  - 1000 J: 011, 0, 0 | 00001
  - 1001 BRZ: 011, 0, 0 | 00010
  - 1010 JM: 001, 1, 0 | 00001
  - 1011 BRN: 011, 0, 0 | 00010
  - Every other code is illegal and decodes to the all-zero bundle.
- Stall (combinational): stall_out = id_valid & ex_valid & ex_MemRead & (ex_rd==id_rs | ex_rd==id_rt) & ~flush.
- ID/EX register update:
  - If flush, stall_out or ~id_valid: load a bubble (all control 0, ex_valid=0, ex_rd=0).
  - Otherwise load the decoded bundle, id_rd, and ex_valid=1.
- EX/MEM register update:
  - If flush: load a bubble.
  - Otherwise copy ID/EX (MEM fields plus MemRead/MemWrite, rd, valid).
- MEM/WB register update: always copies EX/MEM. The flushing branch itself retires.
- Latency: ID to EX, EX to MEM, and MEM to WB are one cycle each.
- A load-use stall lasts exactly one cycle. The next cycle ID/EX holds a bubble, so stall_out drops.
- Flush plus a hazard in the same cycle: flush wins, stall_out=0, and both young stages are bubbled.
- Illegal opcode: when id_valid & ~stall_out & ~flush and the opcode is undefined:
  - the instruction enters ID/EX as a valid all-zero bundle;
  - illegal_op is set and cleared only by reset;
  - illegal_cnt increments and holds at 2^CNT_W-1.
- A stalled or flushed illegal opcode does not count. It is counted when it actually issues.

Decomposition:
- ctrl_pkg contains:
  - opcode localparams;
  - bundle bit-index localparams;
  - bubble constant;
  - decode function returning {ALUOp, MemRead, MemWrite, MEM5} plus an illegal flag.
- Sub-module ctrl_decode: purely combinational table wrapper around the package function, instantiated once inside ctrl_pipe.

Test Plan:
- Reset mid-stream:
  - Stimulus: ADD in flight, then rst_n=0 asynchronously between edges.
  - Required: all valids, ctrl, illegal_op and illegal_cnt read 0 immediately.
  - Required: after release, the first ID instruction appears at EX one edge later.
- Full table sweep:
  - Stimulus: issue each of the 12 defined opcodes back-to-back with id_valid=1.
  - Required: ex_alu_op, mem_ctrl and wb_ctrl match the table at cycles +1, +2 and +3.
  - Required: illegal_op stays 0.
- Load-use hazard:
  - Stimulus: LD rd=5, then ADD rs=5.
  - Required: stall_out=1 for exactly one cycle; a bubble appears at EX (ex_valid=0); ADD reaches EX one cycle late.
  - Stimulus: LD rd=5, then ADD rs=6 rt=7.
  - Required: no stall.
- Flush:
  - Stimulus: BRZ, ADD, SUB; assert flush when BRZ reaches MEM.
  - Required: the BRZ bundle reaches WB.
  - Required: ADD (EX) and SUB (ID) are bubbled; mem_valid=0 and ex_valid=0 next cycle.
- Flush and hazard together:
  - Stimulus: LD in EX matching the ID rs, with flush=1 in the same cycle.
  - Required: stall_out=0 and both young stages are bubbled.
- Illegal opcodes:
  - Stimulus: issue 0001, 1100, then 0001 under stall.
  - Required: illegal_op=1 and illegal_cnt=2 after the unstalled issue.
  - Stimulus: with CNT_W=2, issue 5 illegal opcodes.
  - Required: illegal_cnt saturates at 3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, opcode map and the decode table for the pipelined controller.
package ctrl_pkg;

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpSvpc = 4'b1111;
  localparam logic [3:0] OpLd   = 4'b1110;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpAdd  = 4'b0100;
  localparam logic [3:0] OpInc  = 4'b0101;
  localparam logic [3:0] OpNeg  = 4'b0110;
  localparam logic [3:0] OpSub  = 4'b0111;
  localparam logic [3:0] OpJ    = 4'b1000;
  localparam logic [3:0] OpBrz  = 4'b1001;
  localparam logic [3:0] OpJm   = 4'b1010;
  localparam logic [3:0] OpBrn  = 4'b1011;

  // Bit positions inside the 7-bit MEM bundle.
  localparam int unsigned MemReadBit  = 6;
  localparam int unsigned MemWriteBit = 5;
  localparam int unsigned RegWriteBit = 4;
  localparam int unsigned MemToRegBit = 3;
  localparam int unsigned PcToRegBit  = 2;
  localparam int unsigned BranchBit   = 1;
  localparam int unsigned JumpBit     = 0;

  localparam int unsigned AluW     = 3;
  localparam int unsigned MemCtrlW = 7;
  localparam int unsigned WbCtrlW  = 3;

  typedef struct packed {
    logic [AluW-1:0]     alu_op;
    logic [MemCtrlW-1:0] mem;
  } ctrl_t;

  localparam int unsigned CtrlW = $bits(ctrl_t);
  localparam ctrl_t CtrlBubble = '0;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
  } dec_t;

  function automatic dec_t decode(logic [3:0] op);
    dec_t d;
    d.ctrl    = CtrlBubble;
    d.illegal = 1'b0;
    case (op)
      OpNop:   d.ctrl = {3'b011, 7'b0000000};
      OpSvpc:  d.ctrl = {3'b111, 7'b0010100};
      OpLd:    d.ctrl = {3'b111, 7'b1011000};
      OpSt:    d.ctrl = {3'b111, 7'b0100000};
      OpAdd:   d.ctrl = {3'b100, 7'b0010000};
      OpInc:   d.ctrl = {3'b010, 7'b0010000};
      OpNeg:   d.ctrl = {3'b001, 7'b0010000};
      OpSub:   d.ctrl = {3'b000, 7'b0010000};
      OpJ:     d.ctrl = {3'b011, 7'b0000001};
      OpBrz:   d.ctrl = {3'b011, 7'b0000010};
      OpJm:    d.ctrl = {3'b001, 7'b1000001};
      OpBrn:   d.ctrl = {3'b011, 7'b0000010};
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an ID-stage opcode to its control bundle and illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CtrlW-1:0]    ctrl,
  output logic                illegal
);

  logic [OPCODE_W-1:0] opcode_hi;
  dec_t                dec;

  always_comb begin
    // Any bit above the 4-bit table makes the code undefined.
    opcode_hi = opcode >> 4;
    dec       = decode(4'(opcode));
    ctrl      = dec.ctrl;
    illegal   = dec.illegal | (|opcode_hi);
    if (|opcode_hi) begin
      ctrl = CtrlBubble;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined controller: decodes ID opcodes and carries control through ID/EX, EX/MEM, MEM/WB,
// with load-use stall, taken-branch flush and illegal-opcode capture.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned REG_W    = 6,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                flush,
  output logic                stall_out,
  output logic                ex_valid,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic [REG_W-1:0]    ex_rd,
  output logic                mem_valid,
  output logic [6:0]          mem_ctrl,
  output logic                wb_valid,
  output logic [2:0]          wb_ctrl,
  output logic [REG_W-1:0]    wb_rd,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    illegal_cnt
);

  logic [CtrlW-1:0] dec_ctrl;
  logic             dec_illegal;
  ctrl_t            id_ctrl;

  ctrl_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .opcode (id_opcode),
    .ctrl   (dec_ctrl),
    .illegal(dec_illegal)
  );

  assign id_ctrl = dec_ctrl;

  logic                  ex_valid_q, ex_valid_d;
  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic [REG_W-1:0]      ex_rd_q, ex_rd_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [MemCtrlW-1:0]   mem_ctrl_q, mem_ctrl_d;
  logic [REG_W-1:0]      mem_rd_q, mem_rd_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [WbCtrlW-1:0]    wb_ctrl_q, wb_ctrl_d;
  logic [REG_W-1:0]      wb_rd_q, wb_rd_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall, issue;

  always_comb begin
    // Flush outranks the hazard: the stalled instruction is being squashed anyway.
    stall = id_valid & ex_valid_q & ex_ctrl_q.mem[MemReadBit] &
            ((ex_rd_q == id_rs) | (ex_rd_q == id_rt)) & ~flush;
    issue = id_valid & ~stall & ~flush;

    ex_valid_d = 1'b0;
    ex_ctrl_d  = CtrlBubble;
    ex_rd_d    = '0;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rd_d    = id_rd;
    end

    mem_valid_d = 1'b0;
    mem_ctrl_d  = '0;
    mem_rd_d    = '0;
    if (!flush) begin
      mem_valid_d = ex_valid_q;
      mem_ctrl_d  = ex_ctrl_q.mem;
      mem_rd_d    = ex_rd_q;
    end

    // The flushing branch sits in MEM, so it still retires.
    wb_valid_d = mem_valid_q;
    wb_ctrl_d  = mem_ctrl_q[RegWriteBit -: WbCtrlW];
    wb_rd_d    = mem_rd_q;

    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (issue && dec_illegal) begin
      illegal_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= CtrlBubble;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall_out   = stall;
  assign ex_valid    = ex_valid_q;
  assign ex_alu_op   = ALUOP_W'(ex_ctrl_q.alu_op);
  assign ex_rd       = ex_rd_q;
  assign mem_valid   = mem_valid_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign wb_valid    = wb_valid_q;
  assign wb_ctrl     = wb_ctrl_q;
  assign wb_rd       = wb_rd_q;
  assign illegal_op  = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: decode table sweep, hazard/flush/illegal/reset sequences,
// and randomized traffic against a stage-by-stage reference model.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_opcode = '0;
  logic [5:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       flush = 1'b0;

  logic       stall_out, ex_valid, mem_valid, wb_valid, illegal_op;
  logic [2:0] ex_alu_op, wb_ctrl;
  logic [5:0] ex_rd, wb_rd;
  logic [6:0] mem_ctrl;
  logic [7:0] illegal_cnt;

  logic       b_stall, b_ex_valid, b_mem_valid, b_wb_valid, b_ill;
  logic [2:0] b_ex_alu, b_wb_ctrl;
  logic [5:0] b_ex_rd, b_wb_rd;
  logic [6:0] b_mem_ctrl;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  ctrl_pipe #(.OPCODE_W(4), .ALUOP_W(3), .REG_W(6), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
    .wb_rd(wb_rd), .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
  );

  // Narrow counter instance to observe saturation.
  ctrl_pipe #(.OPCODE_W(4), .ALUOP_W(3), .REG_W(6), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall_out(b_stall), .ex_valid(b_ex_valid), .ex_alu_op(b_ex_alu), .ex_rd(b_ex_rd),
    .mem_valid(b_mem_valid), .mem_ctrl(b_mem_ctrl), .wb_valid(b_wb_valid), .wb_ctrl(b_wb_ctrl),
    .wb_rd(b_wb_rd), .illegal_op(b_ill), .illegal_cnt(b_cnt)
  );

  typedef struct {
    logic [3:0] op;
    logic [2:0] alu;
    logic [6:0] mem;
    logic [2:0] wb;
  } vec_t;

  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what each stage holds, expressed as decoded fields.
  logic       m_ex_v, m_mem_v, m_wb_v, m_ill;
  logic [2:0] m_ex_alu, m_wb_ctrl;
  logic [6:0] m_ex_mem, m_mem_ctrl;
  logic [5:0] m_ex_rd, m_mem_rd, m_wb_rd;
  int         m_cnt, m_cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [3:0] op, output logic legal,
                                 output logic [2:0] alu, output logic [6:0] mem);
    legal = 1'b0;
    alu   = '0;
    mem   = '0;
    for (int k = 0; k < 12; k++) begin
      if (tbl[k].op == op) begin
        legal = 1'b1;
        alu   = tbl[k].alu;
        mem   = tbl[k].mem;
      end
    end
  endfunction

  function automatic logic exp_stall();
    return id_valid && m_ex_v && m_ex_mem[6] && (m_ex_rd == id_rs || m_ex_rd == id_rt) && !flush;
  endfunction

  task automatic model_reset();
    m_ex_v = 0; m_ex_alu = 0; m_ex_mem = 0; m_ex_rd = 0;
    m_mem_v = 0; m_mem_ctrl = 0; m_mem_rd = 0;
    m_wb_v = 0; m_wb_ctrl = 0; m_wb_rd = 0;
    m_ill = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic compare_all();
    logic [29:0] exp_vec;
    check("stall_out", stall_out, exp_stall());
    check("ex_valid", ex_valid, m_ex_v);
    check("ex_alu_op", ex_alu_op, m_ex_alu);
    check("ex_rd", ex_rd, m_ex_rd);
    check("mem_valid", mem_valid, m_mem_v);
    check("mem_ctrl", mem_ctrl, m_mem_ctrl);
    check("wb_valid", wb_valid, m_wb_v);
    check("wb_ctrl", wb_ctrl, m_wb_ctrl);
    check("wb_rd", wb_rd, m_wb_rd);
    check("illegal_op", illegal_op, m_ill);
    check("illegal_cnt", illegal_cnt, m_cnt);
    check("illegal_cnt_w2", b_cnt, m_cnt2);
    exp_vec = {exp_stall(), m_ex_v, m_ex_alu, m_ex_rd, m_mem_v, m_mem_ctrl, m_wb_v, m_wb_ctrl,
               m_wb_rd, m_ill};
    check("dut2_outputs", {b_stall, b_ex_valid, b_ex_alu, b_ex_rd, b_mem_valid, b_mem_ctrl,
                           b_wb_valid, b_wb_ctrl, b_wb_rd, b_ill}, exp_vec);
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    logic       st, iss, legal;
    logic [2:0] alu;
    logic [6:0] mem;
    logic       n_ex_v, n_mem_v, n_wb_v;
    logic [2:0] n_ex_alu, n_wb_ctrl;
    logic [6:0] n_ex_mem, n_mem_ctrl;
    logic [5:0] n_ex_rd, n_mem_rd, n_wb_rd;
    st  = exp_stall();
    iss = id_valid && !st && !flush;
    lookup(id_opcode, legal, alu, mem);
    n_wb_v = m_mem_v; n_wb_ctrl = m_mem_ctrl[4:2]; n_wb_rd = m_mem_rd;
    n_mem_v = flush ? 1'b0 : m_ex_v;
    n_mem_ctrl = flush ? 7'd0 : m_ex_mem;
    n_mem_rd = flush ? 6'd0 : m_ex_rd;
    n_ex_v = iss;
    n_ex_alu = iss ? alu : 3'd0;
    n_ex_mem = iss ? mem : 7'd0;
    n_ex_rd = iss ? id_rd : 6'd0;
    @(posedge clk);
    #1;
    m_ex_v = n_ex_v; m_ex_alu = n_ex_alu; m_ex_mem = n_ex_mem; m_ex_rd = n_ex_rd;
    m_mem_v = n_mem_v; m_mem_ctrl = n_mem_ctrl; m_mem_rd = n_mem_rd;
    m_wb_v = n_wb_v; m_wb_ctrl = n_wb_ctrl; m_wb_rd = n_wb_rd;
    if (iss && !legal) begin
      m_ill = 1'b1;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [5:0] rs,
                        input logic [5:0] rt, input logic [5:0] rd, input logic fl);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
  endtask

  task automatic idle(input int n);
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0);
    for (int k = 0; k < n; k++) begin
      settle();
      advance();
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 3'b011, 7'b0000000, 3'b000};
    tbl[1]  = '{4'b1111, 3'b111, 7'b0010100, 3'b101};
    tbl[2]  = '{4'b1110, 3'b111, 7'b1011000, 3'b110};
    tbl[3]  = '{4'b0011, 3'b111, 7'b0100000, 3'b000};
    tbl[4]  = '{4'b0100, 3'b100, 7'b0010000, 3'b100};
    tbl[5]  = '{4'b0101, 3'b010, 7'b0010000, 3'b100};
    tbl[6]  = '{4'b0110, 3'b001, 7'b0010000, 3'b100};
    tbl[7]  = '{4'b0111, 3'b000, 7'b0010000, 3'b100};
    tbl[8]  = '{4'b1000, 3'b011, 7'b0000001, 3'b000};
    tbl[9]  = '{4'b1001, 3'b011, 7'b0000010, 3'b000};
    tbl[10] = '{4'b1010, 3'b001, 7'b1000001, 3'b000};
    tbl[11] = '{4'b1011, 3'b011, 7'b0000010, 3'b000};
    model_reset();

    // Reset state.
    #3;
    compare_all();
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full table sweep, back-to-back.
    for (int i = 0; i < 15; i++) begin
      if (i < 12) set_id(1, tbl[i].op, 6'd63, 6'd63, 6'(i), 0);
      else set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0);
      settle();
      if (i >= 1 && i <= 12) begin
        check("sweep_ex_valid", ex_valid, 1);
        check("sweep_ex_alu", ex_alu_op, tbl[i-1].alu);
      end
      if (i >= 2 && i <= 13) check("sweep_mem_ctrl", mem_ctrl, tbl[i-2].mem);
      if (i >= 3) check("sweep_wb_ctrl", wb_ctrl, tbl[i-3].wb);
      advance();
    end
    check("sweep_no_illegal", illegal_op, 0);

    // Load-use hazard: LD r5, ADD r5.
    set_id(1, 4'b1110, 6'd0, 6'd0, 6'd5, 0); settle(); advance();
    set_id(1, 4'b0100, 6'd5, 6'd1, 6'd9, 0); settle();
    check("lu_stall", stall_out, 1);
    advance();
    settle();
    check("lu_bubble", ex_valid, 0);
    check("lu_stall_once", stall_out, 0);
    advance();
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0); settle();
    check("lu_add_late_valid", ex_valid, 1);
    check("lu_add_late_alu", ex_alu_op, 3'b100);
    check("lu_add_late_rd", ex_rd, 6'd9);
    advance();
    idle(3);

    // No hazard: LD r5, ADD r6,r7.
    set_id(1, 4'b1110, 6'd0, 6'd0, 6'd5, 0); settle(); advance();
    set_id(1, 4'b0100, 6'd6, 6'd7, 6'd8, 0); settle();
    check("nohaz_stall", stall_out, 0);
    advance();
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0); settle();
    check("nohaz_add_ex", ex_valid, 1);
    advance();
    idle(3);

    // Flush when BRZ reaches MEM.
    set_id(1, 4'b1001, 6'd2, 6'd3, 6'd1, 0); settle(); advance();
    set_id(1, 4'b0100, 6'd2, 6'd3, 6'd4, 0); settle(); advance();
    set_id(1, 4'b0111, 6'd2, 6'd3, 6'd6, 1); settle();
    check("flush_brz_in_mem", mem_ctrl, 7'b0000010);
    advance();
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0); settle();
    check("flush_brz_wb_valid", wb_valid, 1);
    check("flush_brz_wb_rd", wb_rd, 6'd1);
    check("flush_mem_bubble", mem_valid, 0);
    check("flush_ex_bubble", ex_valid, 0);
    advance();
    idle(3);

    // Flush together with a load-use hazard.
    set_id(1, 4'b1110, 6'd0, 6'd0, 6'd5, 0); settle(); advance();
    set_id(1, 4'b0100, 6'd5, 6'd5, 6'd3, 1); settle();
    check("flushhaz_stall", stall_out, 0);
    advance();
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0); settle();
    check("flushhaz_ex", ex_valid, 0);
    check("flushhaz_mem", mem_valid, 0);
    advance();
    idle(3);

    // Illegal opcodes: two issued, one held by a stall.
    set_id(1, 4'b0001, 6'd63, 6'd63, 6'd2, 0); settle(); advance();
    set_id(1, 4'b1100, 6'd63, 6'd63, 6'd2, 0); settle();
    check("ill_enters_ex", ex_valid, 1);
    check("ill_zero_bundle", ex_alu_op, 3'b000);
    advance();
    set_id(1, 4'b1110, 6'd0, 6'd0, 6'd5, 0); settle();
    check("ill_sticky", illegal_op, 1);
    check("ill_cnt2", illegal_cnt, 8'd2);
    advance();
    set_id(1, 4'b0001, 6'd5, 6'd0, 6'd2, 0); settle();
    check("ill_stalled", stall_out, 1);
    advance();
    settle();
    check("ill_stall_not_counted", illegal_cnt, 8'd2);
    advance();
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0); settle();
    check("ill_counted_on_issue", illegal_cnt, 8'd3);
    advance();
    idle(2);

    // Asynchronous reset mid-stream.
    set_id(1, 4'b0100, 6'd1, 6'd2, 6'd7, 0); settle(); advance();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_mem_ctrl", mem_ctrl, 0);
    check("rst_wb_ctrl", wb_ctrl, 0);
    check("rst_illegal_op", illegal_op, 0);
    check("rst_illegal_cnt", illegal_cnt, 0);
    model_reset();
    rst_n = 1'b1;
    set_id(1, 4'b0100, 6'd1, 6'd2, 6'd12, 0);
    settle(); advance();
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0); settle();
    check("rst_first_ex_valid", ex_valid, 1);
    check("rst_first_ex_rd", ex_rd, 6'd12);
    advance();
    idle(2);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      set_id(1, 4'b1101, 6'd63, 6'd63, 6'd0, 0);
      settle(); advance();
    end
    set_id(0, 4'd0, 6'd0, 6'd0, 6'd0, 0); settle();
    check("sat_cnt_w2", b_cnt, 2'd3);
    check("sat_cnt_w8", illegal_cnt, 8'd5);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom % 8) != 0, 4'($urandom % 16), 6'($urandom % 4), 6'($urandom % 4),
             6'($urandom % 4), ($urandom % 8) == 0);
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
